// File: rtl/decode_stage.sv
// Registered RV32I/RV64I decode stage with load-use interlock, flush and bubble counter.
// Ports: clk/rst, IF/ID valid/ready + instr/pc, flush, ID/EX valid/ready + decoded bundle, bubble_cnt.
module decode_stage #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [XLEN-1:0]  in_pc,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_pc,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [4:0]       rd,
   output logic [XLEN-1:0]  ext_imm,
   output logic [2:0]       alu_op,
   output logic             alu_src,
   output logic             branch_sel,
   output logic             mr_sel,
   output logic             mtr_sel,
   output logic             mw_sel,
   output logic             rw_sel,
   output logic             illegal,
   output logic [CNT_W-1:0] bubble_cnt
);

   localparam logic [6:0] OP_R    = 7'b0110011;
   localparam logic [6:0] OP_I    = 7'b0010011;
   localparam logic [6:0] OP_LD   = 7'b0000011;
   localparam logic [6:0] OP_ST   = 7'b0100011;
   localparam logic [6:0] OP_BR   = 7'b1100011;
   localparam logic [6:0] OP_LUI  = 7'b0110111;
   localparam logic [6:0] OP_AUI  = 7'b0010111;
   localparam logic [6:0] OP_JAL  = 7'b1101111;
   localparam logic [6:0] OP_JALR = 7'b1100111;

   logic [6:0]  opc;
   logic        use1, use2, use_rd;
   logic [31:0] imm32;
   logic [2:0]  op_d;
   logic        src_d, br_d, mr_d, mw_d, ill_d;
   logic        hazard, advance, accept;

   assign opc = in_instr[6:0];

   always_comb begin
      use1   = 1'b0;
      use2   = 1'b0;
      use_rd = 1'b0;
      imm32  = '0;
      op_d   = 3'b000;
      src_d  = 1'b0;
      br_d   = 1'b0;
      mr_d   = 1'b0;
      mw_d   = 1'b0;
      ill_d  = 1'b0;
      case (opc)
         OP_R: begin
            use1 = 1'b1; use2 = 1'b1; use_rd = 1'b1;
            op_d = 3'b010;
         end
         OP_I: begin
            use1 = 1'b1; use_rd = 1'b1;
            imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            op_d = 3'b011; src_d = 1'b1;
         end
         OP_LD: begin
            use1 = 1'b1; use_rd = 1'b1;
            imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            src_d = 1'b1; mr_d = 1'b1;
         end
         OP_ST: begin
            use1 = 1'b1; use2 = 1'b1;
            imm32 = {{20{in_instr[31]}}, in_instr[31:25],
                     in_instr[11:7]};
            src_d = 1'b1; mw_d = 1'b1;
         end
         OP_BR: begin
            use1 = 1'b1; use2 = 1'b1;
            imm32 = {{19{in_instr[31]}}, in_instr[31],
                     in_instr[7], in_instr[30:25],
                     in_instr[11:8], 1'b0};
            op_d = 3'b001; br_d = 1'b1;
         end
         OP_LUI: begin
            use_rd = 1'b1;
            imm32 = {in_instr[31:12], 12'b0};
            op_d = 3'b100; src_d = 1'b1;
         end
         OP_AUI: begin
            use_rd = 1'b1;
            imm32 = {in_instr[31:12], 12'b0};
            op_d = 3'b101; src_d = 1'b1;
         end
         OP_JAL: begin
            use_rd = 1'b1;
            imm32 = {{11{in_instr[31]}}, in_instr[31],
                     in_instr[19:12], in_instr[20],
                     in_instr[30:21], 1'b0};
            op_d = 3'b110; src_d = 1'b1; br_d = 1'b1;
         end
         OP_JALR: begin
            use1 = 1'b1; use_rd = 1'b1;
            imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            op_d = 3'b110; src_d = 1'b1; br_d = 1'b1;
         end
         default: ill_d = 1'b1;
      endcase
   end

   // A load in the output register whose rd feeds the incoming
   // instruction must be let go one cycle ahead of its consumer.
   assign hazard = out_valid && mr_sel && (rd != 5'd0) && in_valid &&
                   ((use1 && in_instr[19:15] == rd) ||
                    (use2 && in_instr[24:20] == rd));

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance && !hazard && !flush;
   assign accept   = in_valid && in_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid  <= 1'b0;
         out_pc     <= '0;
         rs1        <= '0;
         rs2        <= '0;
         rd         <= '0;
         ext_imm    <= '0;
         alu_op     <= '0;
         alu_src    <= 1'b0;
         branch_sel <= 1'b0;
         mr_sel     <= 1'b0;
         mtr_sel    <= 1'b0;
         mw_sel     <= 1'b0;
         rw_sel     <= 1'b0;
         illegal    <= 1'b0;
         bubble_cnt <= '0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (advance) begin
         out_valid <= accept;
         if (accept) begin
            out_pc     <= in_pc;
            rs1        <= use1 ? in_instr[19:15] : 5'd0;
            rs2        <= use2 ? in_instr[24:20] : 5'd0;
            rd         <= use_rd ? in_instr[11:7] : 5'd0;
            ext_imm    <= XLEN'($signed(imm32));
            alu_op     <= op_d;
            alu_src    <= src_d;
            branch_sel <= br_d;
            mr_sel     <= mr_d;
            mtr_sel    <= mr_d;
            mw_sel     <= mw_d;
            rw_sel     <= use_rd && (in_instr[11:7] != 5'd0);
            illegal    <= ill_d;
         end
         if (hazard && bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode fields, handshake, interlock, flush, reset.
// Drives inputs #1 after rising edges and checks outputs there as well.
module tb_decode_stage;

   localparam int XLEN  = 32;
   localparam int CNT_W = 2;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [XLEN-1:0]  in_pc;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_pc;
   logic [4:0]       rs1, rs2, rd;
   logic [XLEN-1:0]  ext_imm;
   logic [2:0]       alu_op;
   logic             alu_src, branch_sel, mr_sel, mtr_sel;
   logic             mw_sel, rw_sel, illegal;
   logic [CNT_W-1:0] bubble_cnt;

   int n_chk  = 0;
   int n_fail = 0;

   localparam logic [31:0] I_ADD   = 32'h002081B3;
   localparam logic [31:0] I_ADDI  = 32'h06320813;
   localparam logic [31:0] I_BEQ   = 32'h00208463;
   localparam logic [31:0] I_LW    = 32'h0000A283;
   localparam logic [31:0] I_ADD6  = 32'h00228333;
   localparam logic [31:0] I_LUI   = 32'h000010B7;
   localparam logic [31:0] I_SW    = 32'h0020A223;
   localparam logic [31:0] I_ADDM1 = 32'hFFF00093;

   always #5 clk = ~clk;

   decode_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_instr(in_instr), .in_pc(in_pc),
      .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc),
      .rs1(rs1), .rs2(rs2), .rd(rd),
      .ext_imm(ext_imm), .alu_op(alu_op), .alu_src(alu_src),
      .branch_sel(branch_sel), .mr_sel(mr_sel), .mtr_sel(mtr_sel),
      .mw_sel(mw_sel), .rw_sel(rw_sel), .illegal(illegal),
      .bubble_cnt(bubble_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic settle;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_instr = 32'h0;
      in_pc = '0;
      flush = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      chk("rst out_valid", 32'(out_valid), 0);
      chk("rst bubble", 32'(bubble_cnt), 0);
      chk("rst illegal", 32'(illegal), 0);
      chk("rst rd", 32'(rd), 0);
      chk("rst ext_imm", ext_imm, 0);
      chk("rst in_ready", 32'(in_ready), 1);
      rst = 1'b0;

      // ADD x3,x1,x2
      in_valid = 1'b1; in_instr = I_ADD; in_pc = 32'h100;
      tick();
      chk("add valid", 32'(out_valid), 1);
      chk("add rd", 32'(rd), 3);
      chk("add rs1", 32'(rs1), 1);
      chk("add rs2", 32'(rs2), 2);
      chk("add op", 32'(alu_op), 3'b010);
      chk("add rw", 32'(rw_sel), 1);
      chk("add src", 32'(alu_src), 0);
      chk("add imm", ext_imm, 0);
      chk("add pc", out_pc, 32'h100);

      // ADDI x16,x4,99
      in_instr = I_ADDI; in_pc = 32'h104;
      tick();
      chk("addi rd", 32'(rd), 16);
      chk("addi rs1", 32'(rs1), 4);
      chk("addi rs2", 32'(rs2), 0);
      chk("addi imm", ext_imm, 99);
      chk("addi op", 32'(alu_op), 3'b011);
      chk("addi src", 32'(alu_src), 1);

      // BEQ x1,x2,+8
      in_instr = I_BEQ; in_pc = 32'h108;
      tick();
      chk("beq imm", ext_imm, 8);
      chk("beq br", 32'(branch_sel), 1);
      chk("beq rw", 32'(rw_sel), 0);
      chk("beq rd", 32'(rd), 0);
      chk("beq op", 32'(alu_op), 3'b001);

      // SW x2,4(x1)
      in_instr = I_SW;
      tick();
      chk("sw mw", 32'(mw_sel), 1);
      chk("sw imm", ext_imm, 4);
      chk("sw rd", 32'(rd), 0);
      chk("sw rs2", 32'(rs2), 2);

      // ADDI x1,x0,-1: negative immediate sign extension
      in_instr = I_ADDM1;
      tick();
      chk("addi-1 imm", ext_imm, 32'hFFFFFFFF);
      chk("addi-1 rs1", 32'(rs1), 0);

      // unsupported opcode
      in_instr = 32'hFFFFFFFF;
      tick();
      chk("ill valid", 32'(out_valid), 1);
      chk("ill flag", 32'(illegal), 1);
      chk("ill rw", 32'(rw_sel), 0);
      chk("ill mw", 32'(mw_sel), 0);

      // LW x5 then dependent ADD x6,x5,x2
      in_instr = I_LW;
      tick();
      chk("lw valid", 32'(out_valid), 1);
      chk("lw mr", 32'(mr_sel), 1);
      chk("lw mtr", 32'(mtr_sel), 1);
      chk("lw rd", 32'(rd), 5);
      chk("lw ill", 32'(illegal), 0);
      in_instr = I_ADD6;
      settle();
      chk("lu in_ready", 32'(in_ready), 0);
      tick();
      chk("lu bubble", 32'(out_valid), 0);
      chk("lu cnt", 32'(bubble_cnt), 1);
      tick();
      chk("lu add valid", 32'(out_valid), 1);
      chk("lu add rd", 32'(rd), 6);
      chk("lu add rs1", 32'(rs1), 5);

      // more load-use pairs push the 2-bit counter into saturation
      for (int k = 0; k < 3; k++) begin
         in_instr = I_LW;
         tick();
         in_instr = I_ADD6;
         tick();
         chk("sat bubble", 32'(out_valid), 0);
         chk("sat cnt", 32'(bubble_cnt), (k == 0) ? 2 : 3);
         tick();
         chk("sat add rd", 32'(rd), 6);
      end

      // reset, then load-use with EX stalled: hold, no count
      rst = 1'b1;
      settle();
      rst = 1'b0;
      in_instr = I_LW;
      tick();
      out_ready = 1'b0;
      in_instr = I_ADD6;
      tick();
      tick();
      chk("stall valid", 32'(out_valid), 1);
      chk("stall mr", 32'(mr_sel), 1);
      chk("stall cnt", 32'(bubble_cnt), 0);
      chk("stall ready", 32'(in_ready), 0);

      // asynchronous reset in the middle of that stall
      #2;
      rst = 1'b1;
      #1;
      chk("arst valid", 32'(out_valid), 0);
      chk("arst mr", 32'(mr_sel), 0);
      chk("arst rd", 32'(rd), 0);
      chk("arst cnt", 32'(bubble_cnt), 0);
      rst = 1'b0;
      out_ready = 1'b1;
      in_valid = 1'b0;
      tick();

      // flush while EX stalls
      in_valid = 1'b1; in_instr = I_ADDI;
      tick();
      out_ready = 1'b0;
      in_instr = I_ADD;
      flush = 1'b1;
      settle();
      chk("fl in_ready", 32'(in_ready), 0);
      tick();
      chk("fl valid", 32'(out_valid), 0);
      flush = 1'b0;
      tick();
      chk("fl held valid", 32'(out_valid), 1);
      chk("fl held rd", 32'(rd), 3);
      chk("fl cnt", 32'(bubble_cnt), 0);
      out_ready = 1'b1;

      // flush coinciding with a load-use hazard
      in_instr = I_LW;
      tick();
      in_instr = I_ADD6;
      flush = 1'b1;
      tick();
      chk("flhz valid", 32'(out_valid), 0);
      chk("flhz cnt", 32'(bubble_cnt), 0);
      flush = 1'b0;
      tick();
      chk("flhz add rd", 32'(rd), 6);
      chk("flhz cnt2", 32'(bubble_cnt), 0);

      // LUI held for three cycles under backpressure
      in_instr = I_LUI;
      tick();
      out_ready = 1'b0;
      in_instr = I_ADD;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("lui valid", 32'(out_valid), 1);
         chk("lui imm", ext_imm, 32'h1000);
         chk("lui op", 32'(alu_op), 3'b100);
         chk("lui rd", 32'(rd), 1);
         chk("lui ready", 32'(in_ready), 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
